// File: rtl/vga_audio_nco_clkgen.sv
// Multi-channel NCO clock generator: per-channel phase accumulators whose frequency
// words change only at wrap, with phase resync and a settle/lock indicator.
module vga_audio_nco_clkgen #(
    parameter int NUM_CH      = 3,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_freq,
    input  logic [ACC_W-1:0]  cfg_phase,
    input  logic              resync,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] tick,
    output logic              cfg_err,
    output logic              locked
);
    localparam int                LK_W     = $clog2(LOCK_CYCLES + 1);
    localparam logic [LK_W-1:0]   LOCK_MAX = LK_W'(LOCK_CYCLES);
    localparam logic [CH_W:0]     NUM_CH_L = (CH_W + 1)'(NUM_CH);

    // Asserts immediately with rst_n, deasserts two refclk edges after release.
    logic [1:0] rst_sync_reg;
    logic       rst_int_n;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_reg[1];

    logic [NUM_CH-1:0] pend_vec;
    logic [NUM_CH-1:0] pend_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [ACC_W-1:0] acc_reg;
            logic [ACC_W-1:0] acc_next;
            logic [ACC_W-1:0] freq_act_reg;
            logic [ACC_W-1:0] freq_shd_reg;
            logic [ACC_W-1:0] phase_reg;
            logic             pend_reg;
            logic             outclk_reg;
            logic             tick_reg;
            logic [ACC_W:0]   sum;
            logic             wr;
            logic             commit;

            assign wr     = cfg_we && (cfg_ch == CH_W'(gi));
            assign sum    = {1'b0, acc_reg} + {1'b0, freq_act_reg};
            // Disabled channels never wrap, so they commit on the next edge instead.
            assign commit = pend_reg && (sum[ACC_W] || (freq_act_reg == '0) || resync);
            assign pend_next[gi] = wr || (pend_reg && !commit);

            always_comb begin
                acc_next = sum[ACC_W-1:0];
                if (resync) begin
                    acc_next = wr ? cfg_phase : phase_reg;
                end
            end

            always_ff @(posedge refclk or negedge rst_int_n) begin
                if (!rst_int_n) begin
                    acc_reg      <= '0;
                    freq_act_reg <= '0;
                    freq_shd_reg <= '0;
                    phase_reg    <= '0;
                    pend_reg     <= 1'b0;
                    outclk_reg   <= 1'b0;
                    tick_reg     <= 1'b0;
                end else begin
                    acc_reg    <= acc_next;
                    outclk_reg <= acc_next[ACC_W-1];
                    tick_reg   <= sum[ACC_W] && !resync;
                    pend_reg   <= pend_next[gi];
                    if (commit) begin
                        freq_act_reg <= freq_shd_reg;
                    end
                    if (wr) begin
                        freq_shd_reg <= cfg_freq;
                        phase_reg    <= cfg_phase;
                    end
                end
            end

            assign outclk[gi]   = outclk_reg;
            assign tick[gi]     = tick_reg;
            assign pend_vec[gi] = pend_reg;
        end
    endgenerate

    logic [LK_W-1:0] lock_cnt_reg;
    logic [LK_W-1:0] lock_cnt_next;
    logic            locked_reg;
    logic            cfg_err_reg;
    logic            cfg_err_next;

    always_comb begin
        lock_cnt_next = lock_cnt_reg;
        if (cfg_we || resync) begin
            lock_cnt_next = '0;
        end else if (lock_cnt_reg != LOCK_MAX) begin
            lock_cnt_next = lock_cnt_reg + LK_W'(1);
        end
    end

    assign cfg_err_next = cfg_we && ({1'b0, cfg_ch} >= NUM_CH_L);

    always_ff @(posedge refclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            lock_cnt_reg <= '0;
            locked_reg   <= 1'b0;
            cfg_err_reg  <= 1'b0;
        end else begin
            lock_cnt_reg <= lock_cnt_next;
            locked_reg   <= (lock_cnt_next == LOCK_MAX) && (pend_next == '0);
            cfg_err_reg  <= cfg_err_next;
        end
    end

    assign locked  = locked_reg;
    assign cfg_err = cfg_err_reg;

endmodule

// File: tb/tb_vga_audio_nco_clkgen.sv
// Directed bench for vga_audio_nco_clkgen (NUM_CH=3, ACC_W=8, LOCK_CYCLES=4):
// a per-cycle vector table followed by hand-written reset sequences.
module tb_vga_audio_nco_clkgen;
    logic       refclk;
    logic       rst_n;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_freq;
    logic [7:0] cfg_phase;
    logic       resync;
    logic [2:0] outclk;
    logic [2:0] tick;
    logic       cfg_err;
    logic       locked;

    int checks = 0;
    int errors = 0;

    vga_audio_nco_clkgen #(
        .NUM_CH(3),
        .ACC_W(8),
        .LOCK_CYCLES(4)
    ) dut (
        .refclk(refclk),
        .rst_n(rst_n),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_freq(cfg_freq),
        .cfg_phase(cfg_phase),
        .resync(resync),
        .outclk(outclk),
        .tick(tick),
        .cfg_err(cfg_err),
        .locked(locked)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    typedef struct {
        logic       we;
        logic [1:0] ch;
        logic [7:0] freq;
        logic [7:0] phase;
        logic       rs;
        logic [2:0] oc;
        logic [2:0] tk;
        logic       er;
        logic       lk;
    } vec_t;

    localparam int NV = 53;
    vec_t vecs[NV];
    int   nfill = 0;

    task automatic add(input logic we, input logic [1:0] ch, input logic [7:0] f,
                       input logic [7:0] p, input logic rs, input logic [2:0] oc,
                       input logic [2:0] tk, input logic er, input logic lk);
        vecs[nfill].we    = we;
        vecs[nfill].ch    = ch;
        vecs[nfill].freq  = f;
        vecs[nfill].phase = p;
        vecs[nfill].rs    = rs;
        vecs[nfill].oc    = oc;
        vecs[nfill].tk    = tk;
        vecs[nfill].er    = er;
        vecs[nfill].lk    = lk;
        nfill++;
    endtask

    task automatic idle(input logic [2:0] oc, input logic [2:0] tk, input logic er, input logic lk);
        add(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, oc, tk, er, lk);
    endtask

    task automatic check(input string name, input int row, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %0h expected %0h", name, row, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] ch, input logic [7:0] f,
                         input logic [7:0] p, input logic rs);
        cfg_we    = we;
        cfg_ch    = ch;
        cfg_freq  = f;
        cfg_phase = p;
        resync    = rs;
    endtask

    initial begin
        // ch0 freq 64: period 4, then lock after 4 quiet edges
        add(1, 0, 64, 0, 0, 3'b000, 3'b000, 0, 0);
        idle(3'b000, 3'b000, 0, 0);
        idle(3'b000, 3'b000, 0, 0);
        idle(3'b001, 3'b000, 0, 0);
        idle(3'b001, 3'b000, 0, 1);
        idle(3'b000, 3'b001, 0, 1);
        idle(3'b000, 3'b000, 0, 1);
        idle(3'b001, 3'b000, 0, 1);
        idle(3'b001, 3'b000, 0, 1);
        idle(3'b000, 3'b001, 0, 1);
        // mid-period change to 128 takes effect only after the next wrap
        add(1, 0, 128, 0, 0, 3'b000, 3'b000, 0, 0);
        idle(3'b001, 3'b000, 0, 0);
        idle(3'b001, 3'b000, 0, 0);
        idle(3'b000, 3'b001, 0, 0);
        idle(3'b001, 3'b000, 0, 1);
        idle(3'b000, 3'b001, 0, 1);
        idle(3'b001, 3'b000, 0, 1);
        idle(3'b000, 3'b001, 0, 1);
        // pending 64, then a write of 32 on the wrap edge
        add(1, 0, 64, 0, 0, 3'b001, 3'b000, 0, 0);
        add(1, 0, 32, 0, 0, 3'b000, 3'b001, 0, 0);
        idle(3'b000, 3'b000, 0, 0);
        idle(3'b001, 3'b000, 0, 0);
        idle(3'b001, 3'b000, 0, 0);
        idle(3'b000, 3'b001, 0, 1);
        idle(3'b000, 3'b000, 0, 1);
        idle(3'b000, 3'b000, 0, 1);
        idle(3'b000, 3'b000, 0, 1);
        idle(3'b001, 3'b000, 0, 1);
        idle(3'b001, 3'b000, 0, 1);
        idle(3'b001, 3'b000, 0, 1);
        idle(3'b001, 3'b000, 0, 1);
        idle(3'b000, 3'b001, 0, 1);
        // invalid channel
        add(1, 3, 99, 77, 0, 3'b000, 3'b000, 1, 0);
        idle(3'b000, 3'b000, 0, 0);
        // ch1 phase 0, ch2 phase 128, resync
        add(1, 1, 32, 0, 0, 3'b000, 3'b000, 0, 0);
        add(1, 2, 32, 128, 0, 3'b001, 3'b000, 0, 0);
        add(0, 0, 0, 0, 1, 3'b100, 3'b000, 0, 0);
        idle(3'b100, 3'b000, 0, 0);
        idle(3'b100, 3'b000, 0, 0);
        idle(3'b100, 3'b000, 0, 0);
        idle(3'b011, 3'b100, 0, 1);
        idle(3'b011, 3'b000, 0, 1);
        idle(3'b011, 3'b000, 0, 1);
        idle(3'b011, 3'b000, 0, 1);
        idle(3'b100, 3'b011, 0, 1);
        // resync with same-cycle write: phase bypass, new freq stays pending
        add(1, 1, 32, 64, 1, 3'b100, 3'b000, 0, 0);
        idle(3'b100, 3'b000, 0, 0);
        idle(3'b110, 3'b000, 0, 0);
        idle(3'b110, 3'b000, 0, 0);
        idle(3'b011, 3'b100, 0, 0);
        idle(3'b011, 3'b000, 0, 0);
        idle(3'b001, 3'b010, 0, 1);
        idle(3'b001, 3'b000, 0, 1);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (3) @(posedge refclk);
        #1;
        check("rst_outclk", -1, {5'd0, outclk}, 8'd0);
        check("rst_tick", -1, {5'd0, tick}, 8'd0);
        check("rst_cfg_err", -1, {7'd0, cfg_err}, 8'd0);
        check("rst_locked", -1, {7'd0, locked}, 8'd0);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge refclk);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].we, vecs[i].ch, vecs[i].freq, vecs[i].phase, vecs[i].rs);
            @(posedge refclk);
            #1;
            check("outclk", i, {5'd0, outclk}, {5'd0, vecs[i].oc});
            check("tick", i, {5'd0, tick}, {5'd0, vecs[i].tk});
            check("cfg_err", i, {7'd0, cfg_err}, {7'd0, vecs[i].er});
            check("locked", i, {7'd0, locked}, {7'd0, vecs[i].lk});
        end
        drive(0, 0, 0, 0, 0);

        // asynchronous reset between edges clears outputs at once
        #3 rst_n = 1'b0;
        #1;
        check("async_outclk", 100, {5'd0, outclk}, 8'd0);
        check("async_tick", 100, {5'd0, tick}, 8'd0);
        check("async_locked", 100, {7'd0, locked}, 8'd0);
        check("async_cfg_err", 100, {7'd0, cfg_err}, 8'd0);
        repeat (2) @(posedge refclk);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge refclk);
        for (int i = 0; i < 8; i++) begin
            @(posedge refclk);
            #1;
            check("post_rst_outclk", 200 + i, {5'd0, outclk}, 8'd0);
            check("post_rst_tick", 200 + i, {5'd0, tick}, 8'd0);
        end

        // fresh write after reset: freq 128 gives period 2
        drive(1, 0, 128, 0, 0);
        @(posedge refclk);
        #1;
        drive(0, 0, 0, 0, 0);
        @(posedge refclk);
        #1;
        check("restart_commit_outclk", 300, {5'd0, outclk}, 8'd0);
        @(posedge refclk);
        #1;
        check("restart_high_outclk", 301, {5'd0, outclk}, 8'd1);
        @(posedge refclk);
        #1;
        check("restart_tick", 302, {5'd0, tick}, 8'd1);
        check("restart_low_outclk", 302, {5'd0, outclk}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
